// File: rtl/b06_pkg.sv
// Shared encodings and monitor state type for the b06 peer environment.
package b06_pkg;

    localparam logic [1:0] CC_NONE = 2'b00;
    localparam logic [1:0] CC_A    = 2'b01;
    localparam logic [1:0] CC_B    = 2'b10;
    localparam logic [1:0] CC_ONES = 2'b11;

    localparam logic [1:0] US_IDLE  = 2'b00;
    localparam logic [1:0] US_ACT   = 2'b01;
    localparam logic [1:0] US_ILL   = 2'b10;
    localparam logic [1:0] US_ALARM = 2'b11;

    typedef enum logic [1:0] {
        MonIdle,
        MonActive,
        MonAlarm,
        MonError
    } mon_state_t;

    function automatic mon_state_t decode_uscite(input logic [1:0] us);
        mon_state_t st;
        unique case (us)
            US_IDLE:  st = MonIdle;
            US_ACT:   st = MonActive;
            US_ALARM: st = MonAlarm;
            default:  st = MonError;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/b06_env_if.sv
// Signal bundle between the b06 controller side (master) and the peer environment (slave).
interface b06_env_if #(
    parameter int unsigned WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic [WIDTH-1:0] ref_a;
    logic [WIDTH-1:0] ref_b;
    logic [1:0]       cc_mux;
    logic             enable_count;
    logic             ackout;
    logic [1:0]       uscite;
    logic             eql;
    logic             cont_eql;
    logic [WIDTH-1:0] count;
    logic             event_valid;
    logic [1:0]       event_code;
    logic [7:0]       alarm_cnt;
    logic             illegal;

    modport master (
        output data_in, data_valid, ref_a, ref_b, cc_mux, enable_count, ackout, uscite,
        input  eql, cont_eql, count, event_valid, event_code, alarm_cnt, illegal
    );

    modport slave (
        input  data_in, data_valid, ref_a, ref_b, cc_mux, enable_count, ackout, uscite,
        output eql, cont_eql, count, event_valid, event_code, alarm_cnt, illegal
    );
endinterface

// File: rtl/b06_env_counter.sv
// Gated up-counter that saturates at LIMIT; cont_eql is decoded from the register only.
module b06_env_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count,
    output logic             o_cont_eql
);
    localparam logic [WIDTH-1:0] LimitW = WIDTH'(LIMIT);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_d;

    // Clear has priority over the hold at LIMIT.
    always_comb begin
        w_count_d = r_count;
        if (!i_enable) begin
            w_count_d = '0;
        end else if (r_count != LimitW) begin
            w_count_d = r_count + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_d;
        end
    end

    assign o_count    = r_count;
    assign o_cont_eql = (r_count == LimitW);
endmodule

// File: rtl/b06_env.sv
// Peer environment for b06: counter, selectable-reference comparator and uscite monitor.
module b06_env
    import b06_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LIMIT = 5
) (
    input  logic      clock,
    input  logic      reset,
    b06_env_if.slave  bus
);
    logic [WIDTH-1:0] w_count;
    logic             w_cont_eql;

    b06_env_counter #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .i_enable   (bus.enable_count),
        .o_count    (w_count),
        .o_cont_eql (w_cont_eql)
    );

    logic [WIDTH-1:0] w_ref;
    logic             w_eql_d;
    logic             r_eql;

    always_comb begin
        w_ref = '0;
        unique case (bus.cc_mux)
            CC_A:    w_ref = bus.ref_a;
            CC_B:    w_ref = bus.ref_b;
            CC_ONES: w_ref = '1;
            default: w_ref = '0;
        endcase
    end

    // CC_NONE never matches, even when data_in happens to be zero.
    always_comb begin
        w_eql_d = r_eql;
        if (bus.data_valid) begin
            w_eql_d = (bus.cc_mux != CC_NONE) && (bus.data_in == w_ref);
        end
    end

    mon_state_t r_state;
    mon_state_t w_state_next;
    logic [1:0] r_prev_uscite;
    logic       r_event_valid;
    logic       w_event_valid_d;
    logic [1:0] r_event_code;
    logic [1:0] w_event_code_d;
    logic [7:0] r_alarm_cnt;
    logic [7:0] w_alarm_cnt_d;
    logic       r_illegal;
    logic       w_illegal_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= MonIdle;
            r_prev_uscite <= US_IDLE;
            r_event_valid <= 1'b0;
            r_event_code  <= 2'b00;
            r_alarm_cnt   <= 8'd0;
            r_illegal     <= 1'b0;
            r_eql         <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_prev_uscite <= bus.uscite;
            r_event_valid <= w_event_valid_d;
            r_event_code  <= w_event_code_d;
            r_alarm_cnt   <= w_alarm_cnt_d;
            r_illegal     <= w_illegal_d;
            r_eql         <= w_eql_d;
        end
    end

    always_comb begin
        w_state_next = decode_uscite(bus.uscite);
    end

    // Changes seen while ackout is low are dropped, not queued.
    always_comb begin
        w_event_valid_d = (bus.uscite != r_prev_uscite) && bus.ackout;
        w_event_code_d  = w_event_valid_d ? bus.uscite : r_event_code;
        w_alarm_cnt_d   = r_alarm_cnt;
        if ((w_state_next == MonAlarm) && (r_state != MonAlarm) && (r_alarm_cnt != 8'hFF)) begin
            w_alarm_cnt_d = r_alarm_cnt + 8'd1;
        end
        w_illegal_d = r_illegal | (w_state_next == MonError);
    end

    assign bus.eql         = r_eql;
    assign bus.cont_eql    = w_cont_eql;
    assign bus.count       = w_count;
    assign bus.event_valid = r_event_valid;
    assign bus.event_code  = r_event_code;
    assign bus.alarm_cnt   = r_alarm_cnt;
    assign bus.illegal     = r_illegal;
endmodule

// File: tb/tb_b06_env.sv
// Table-driven bench for b06_env with a scoreboard queue of expected outputs.
module tb_b06_env;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    b06_env_if #(.WIDTH(8)) bus ();

    b06_env #(
        .WIDTH (8),
        .LIMIT (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       en;
        logic       dv;
        logic [7:0] din;
        logic [1:0] cc;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [1:0] us;
        logic       ack;
        logic [7:0] e_count;
        logic       e_ce;
        logic       e_eql;
        logic       e_ev;
        logic [1:0] e_code;
        logic [7:0] e_alarm;
        logic       e_ill;
    } vec_t;

    typedef struct {
        logic [7:0] count;
        logic       ce;
        logic       eql;
        logic       ev;
        logic [1:0] code;
        logic [7:0] alarm;
        logic       ill;
    } exp_t;

    int n_pass  = 0;
    int n_total = 0;
    exp_t sb_q[$];
    vec_t vecs[25];

    function automatic vec_t mk(
        input logic en, input logic dv, input logic [7:0] din, input logic [1:0] cc,
        input logic [7:0] ra, input logic [7:0] rb, input logic [1:0] us, input logic ack,
        input logic [7:0] ec, input logic ece, input logic eeql, input logic eev,
        input logic [1:0] ecode, input logic [7:0] ealarm, input logic eill);
        vec_t v;
        v.en = en; v.dv = dv; v.din = din; v.cc = cc; v.ra = ra; v.rb = rb;
        v.us = us; v.ack = ack; v.e_count = ec; v.e_ce = ece; v.e_eql = eeql;
        v.e_ev = eev; v.e_code = ecode; v.e_alarm = ealarm; v.e_ill = eill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, " count"}, 32'(bus.count), 32'(e.count));
        check({tag, " cont_eql"}, 32'(bus.cont_eql), 32'(e.ce));
        check({tag, " eql"}, 32'(bus.eql), 32'(e.eql));
        check({tag, " event_valid"}, 32'(bus.event_valid), 32'(e.ev));
        if (e.ev) check({tag, " event_code"}, 32'(bus.event_code), 32'(e.code));
        check({tag, " alarm_cnt"}, 32'(bus.alarm_cnt), 32'(e.alarm));
        check({tag, " illegal"}, 32'(bus.illegal), 32'(e.ill));
    endtask

    task automatic drive(input vec_t v, input string tag);
        exp_t e;
        bus.enable_count = v.en;
        bus.data_valid   = v.dv;
        bus.data_in      = v.din;
        bus.cc_mux       = v.cc;
        bus.ref_a        = v.ra;
        bus.ref_b        = v.rb;
        bus.uscite       = v.us;
        bus.ackout       = v.ack;
        e.count = v.e_count; e.ce = v.e_ce; e.eql = v.e_eql; e.ev = v.e_ev;
        e.code = v.e_code; e.alarm = v.e_alarm; e.ill = v.e_ill;
        sb_q.push_back(e);
        step();
        check_out(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " count"}, 32'(bus.count), 32'd0);
        check({tag, " cont_eql"}, 32'(bus.cont_eql), 32'd0);
        check({tag, " eql"}, 32'(bus.eql), 32'd0);
        check({tag, " event_valid"}, 32'(bus.event_valid), 32'd0);
        check({tag, " event_code"}, 32'(bus.event_code), 32'd0);
        check({tag, " alarm_cnt"}, 32'(bus.alarm_cnt), 32'd0);
        check({tag, " illegal"}, 32'(bus.illegal), 32'd0);
    endtask

    initial begin
        int exp_alarm;

        // Counter: LIMIT=5 reached on the 5th edge, held, then cleared (clear beats hold).
        vecs[0]  = mk(1, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 0,  1, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 0,  2, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 0,  3, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 0,  4, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk(1, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 0,  5, 1, 0, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 0,  5, 1, 0, 0, 0, 0, 0);
        vecs[6]  = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 0,  0, 0, 0, 0, 0, 0, 0);
        // Comparator
        vecs[7]  = mk(0, 1, 8'h3C, 2'd1, 8'h3C, 8'h00, 2'd0, 0,  0, 0, 1, 0, 0, 0, 0);
        vecs[8]  = mk(0, 0, 8'h3C, 2'd2, 8'h3C, 8'h00, 2'd0, 0,  0, 0, 1, 0, 0, 0, 0);
        vecs[9]  = mk(0, 1, 8'h3C, 2'd2, 8'h3C, 8'h00, 2'd0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[10] = mk(0, 1, 8'hFF, 2'd3, 8'h3C, 8'h00, 2'd0, 0,  0, 0, 1, 0, 0, 0, 0);
        vecs[11] = mk(0, 1, 8'hFF, 2'd0, 8'h3C, 8'h00, 2'd0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[12] = mk(0, 1, 8'hFE, 2'd3, 8'h3C, 8'h00, 2'd0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[13] = mk(0, 1, 8'h00, 2'd2, 8'h3C, 8'h00, 2'd0, 0,  0, 0, 1, 0, 0, 0, 0);
        vecs[14] = mk(0, 1, 8'h3D, 2'd1, 8'h3C, 8'h00, 2'd0, 0,  0, 0, 0, 0, 0, 0, 0);
        // Monitor
        vecs[15] = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd1, 1,  0, 0, 0, 1, 1, 0, 0);
        vecs[17] = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd3, 1,  0, 0, 0, 1, 3, 1, 0);
        vecs[18] = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd3, 1,  0, 0, 0, 0, 0, 1, 0);
        vecs[19] = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd1, 1,  0, 0, 0, 1, 1, 1, 0);
        vecs[20] = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 0,  0, 0, 0, 0, 0, 1, 0);
        vecs[21] = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd1, 0,  0, 0, 0, 0, 0, 1, 0);
        vecs[22] = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd2, 1,  0, 0, 0, 1, 2, 1, 1);
        vecs[23] = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 1,  0, 0, 0, 1, 0, 1, 1);
        vecs[24] = mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd0, 1,  0, 0, 0, 0, 0, 1, 1);

        bus.enable_count = 1'b0;
        bus.data_valid   = 1'b0;
        bus.data_in      = '0;
        bus.cc_mux       = '0;
        bus.ref_a        = '0;
        bus.ref_b        = '0;
        bus.uscite       = '0;
        bus.ackout       = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 25; i++) begin
            drive(vecs[i], $sformatf("vec%0d", i));
        end

        // Alarm saturation: 300 more entries into ALARM from a count of 1.
        exp_alarm = 1;
        for (int i = 0; i < 300; i++) begin
            drive(mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd1, 1, 0, 0, 0, 1, 1,
                     8'(exp_alarm), 1), "sat_act");
            if (exp_alarm < 255) exp_alarm++;
            drive(mk(0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 2'd3, 1, 0, 0, 0, 1, 3,
                     8'(exp_alarm), 1), "sat_alarm");
        end
        check("sat final alarm_cnt", 32'(bus.alarm_cnt), 32'd255);

        // Build count=3 while in ALARM with eql high, then reset between edges.
        drive(mk(1, 1, 8'hFF, 2'd3, 8'h00, 8'h00, 2'd3, 1, 1, 0, 1, 0, 0, 255, 1), "pre1");
        drive(mk(1, 1, 8'hFF, 2'd3, 8'h00, 8'h00, 2'd3, 1, 2, 0, 1, 0, 0, 255, 1), "pre2");
        drive(mk(1, 1, 8'hFF, 2'd3, 8'h00, 8'h00, 2'd3, 1, 3, 0, 1, 0, 0, 255, 1), "pre3");
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        #1;
        reset = 1'b0;
        // First edge after reset with uscite=11 and ackout=1 must raise an event.
        drive(mk(1, 0, 8'hFF, 2'd3, 8'h00, 8'h00, 2'd3, 1, 1, 0, 0, 1, 3, 1, 0), "post_reset");
        drive(mk(1, 0, 8'hFF, 2'd3, 8'h00, 8'h00, 2'd3, 1, 2, 0, 0, 0, 0, 1, 0), "post_reset2");

        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/b06_env.md
# b06_env

Peer block for the b06 controller: drives its `eql` and `cont_eql` inputs and consumes its `cc_mux`, `uscite`, `enable_count` and `ackout` outputs. It contains the following pieces:
- a gated counter that answers `enable_count` with `cont_eql`;
- a selectable-reference comparator that answers `cc_mux` with `eql`;
- a monitor FSM that decodes `uscite` into event pulses and sticky status.

It closes the loop around b06 in the subsystem and gives software/bench a decoded view of controller activity.

## Interface
Parameters:
- `WIDTH`, 8: counter and data width.
- `LIMIT`, 5: terminal count; legal range 1..2^WIDTH-1.

Ports:
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; clears all state.
- `data_in` in WIDTH: sample compared against the selected reference.
- `data_valid` in 1: `data_in` is sampled this cycle.
- `ref_a`, `ref_b` in WIDTH: comparison references.
- `cc_mux` in 2: reference select, from b06.
- `enable_count` in 1: counter enable, from b06.
- `ackout` in 1: event qualify, from b06.
- `uscite` in 2: controller status code, from b06.
- `eql` out 1: sample equals selected reference; to b06.
- `cont_eql` out 1: counter at LIMIT; to b06.
- `count` out WIDTH: current counter value.
- `event_valid` out 1: one-cycle pulse on a qualified status change.
- `event_code` out 2: new `uscite` value; valid with `event_valid`.
- `alarm_cnt` out 8: number of entries into ALARM, saturating at 255.
- `illegal` out 1: sticky flag; `uscite`==2'b10 was seen.

## Operation
Reset value of every output and register is 0.

Counter:
- `enable_count`=0: `count`<=0.
- `enable_count`=1 and `count`!=LIMIT: `count`<=`count`+1.
- `enable_count`=1 and `count`==LIMIT: `count` holds.
- `cont_eql` = (`count`==LIMIT), decoded from the register only; no input-to-output combinational path.

Comparator:
- `cc_mux` selects the reference: 00 → none; 01 → `ref_a`; 10 → `ref_b`; 11 → all-ones.
- On `data_valid`=1: `eql`<=(`data_in`==selected ref), or `eql`<=0 when `cc_mux`=00.
- On `data_valid`=0: `eql` holds, even if `cc_mux` changes.

Monitor FSM (states IDLE, ACTIVE, ALARM, ERROR; register `prev_uscite`, reset value 00):
- IDLE←`uscite`00, ACTIVE←01, ALARM←11, evaluated every cycle.
- `uscite`=10 → ERROR and `illegal`<=1. `illegal` is sticky until reset; the FSM leaves ERROR on the next legal code.
- Event: `uscite`!=`prev_uscite` and `ackout`=1 → `event_valid`<=1, `event_code`<=`uscite`.
- A change while `ackout`=0 updates the state and `prev_uscite` but emits no event; the change is lost, not deferred.
- Each transition into ALARM from any other state does `alarm_cnt`<=min(`alarm_cnt`+1, 255); this counts regardless of `ackout`.

## Timing
- `cont_eql`: rises the cycle after the edge at which `count` reaches LIMIT. With `enable_count` held at 1 from reset release, it is high after LIMIT enabled edges.
- `eql`: one-cycle latency from `data_valid`.
- `event_valid`/`event_code`: one-cycle latency from the `uscite` change. Pulse width is exactly one cycle. Back-to-back changes give back-to-back pulses.
- Simultaneous `enable_count`=0 and `count`==LIMIT: clear wins.
- Asserting `reset` mid-operation clears all state immediately and asynchronously. The first post-reset edge with `uscite`!=00 and `ackout`=1 produces an event.

## Structure
- Shared package `b06_pkg` holds:
  - `cc_mux` encodings: `CC_NONE`, `CC_A`, `CC_B`, `CC_ONES`;
  - `uscite` codes: `US_IDLE`=00, `US_ACT`=01, `US_ILL`=10, `US_ALARM`=11;
  - monitor state enum `mon_state_t`.
- One sub-module, `b06_env_counter`: the gated counter with LIMIT hold and `cont_eql` decode, parameterised by WIDTH and LIMIT.
- Comparator and monitor stay in the top module.

## Test plan
- Reset release, `enable_count`=1 held, LIMIT=5 → `count` 1,2,3,4,5,5…; `cont_eql`=1 from the 5th edge. Drop `enable_count` → `count`=0 and `cont_eql`=0 next cycle.
- `cc_mux`=01, `ref_a`=8'h3C, `data_in`=8'h3C with `data_valid` → `eql`=1 next cycle. Switch to `cc_mux`=10, `ref_b`=8'h00 without `data_valid` → `eql` stays 1. Pulse `data_valid` → `eql`=0.
- `cc_mux`=11, `data_in`=8'hFF → `eql`=1. `cc_mux`=00, any data → `eql`=0.
- `ackout`=1, `uscite` sequence 00→01→11→11→01 → three one-cycle pulses with codes 01, 11, 01; `alarm_cnt`=1. Repeat the 01→11 toggle 300 times → `alarm_cnt`=255.
- `uscite`=01 with `ackout`=0 → no event. Then `uscite`=10 with `ackout`=1 → event code 10 and `illegal`=1. Back to 00 → `illegal` stays 1.
- Assert `reset` between clock edges while `count`=3 and in ALARM → all outputs 0 before the next edge; `alarm_cnt`=0.
